mlp_layer_sequencer: RTL

// - Top-level layer controller for the MLP inference datapath. Runs NUM_LAYERS layers in order.
// - Per layer: pulses the dense/MAC engine, waits for its done, then pulses the ReLU stage and waits for its done.
// - Toggles the ping-pong activation buffer select between layers; reports busy/done/err to the host.

---
 rtl/mlp_layer_sequencer_if.sv | 27 ++
 rtl/mlp_layer_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Host/engine handshake bundle for the MLP layer sequencer.
// The sequencer connects through the slave modport; the host and engines use master.
interface mlp_layer_sequencer_if #(
    parameter int unsigned LAYER_IDX_W = 2
);
    logic                   start;
    logic                   abort;
    logic                   mac_done;
    logic                   relu_done;
    logic                   mac_start;
    logic                   relu_start;
    logic [LAYER_IDX_W-1:0] layer_idx;
    logic                   buf_sel;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, abort, mac_done, relu_done,
        input  mac_start, relu_start, layer_idx, buf_sel, busy, done, err
    );

    modport slave (
        input  start, abort, mac_done, relu_done,
        output mac_start, relu_start, layer_idx, buf_sel, busy, done, err
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Layer controller: runs NUM_LAYERS MAC passes with optional ReLU, ping-pongs the activation buffer.
// Optional watchdog on the wait states is enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_layer_sequencer #(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned LAYER_IDX_W    = 2,
    parameter int unsigned LAST_RELU      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    mlp_layer_sequencer_if.slave  ctrl
);
    localparam logic [LAYER_IDX_W-1:0] LAST_IDX = LAYER_IDX_W'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAC_GO   = 3'd1,
        MAC_WAIT = 3'd2,
        ACT_GO   = 3'd3,
        ACT_WAIT = 3'd4,
        NEXT     = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [LAYER_IDX_W-1:0] layer_idx_q, layer_idx_d;
    logic                   buf_sel_q, buf_sel_d;
    logic                   err_q, err_d;
    logic                   mac_start_q, mac_start_d;
    logic                   relu_start_q, relu_start_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   relu_applies;

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired;
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    assign relu_applies = (layer_idx_q < LAST_IDX) || (LAST_RELU != 0);

    // Next-state and next-output logic; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        buf_sel_d   = buf_sel_q;
        err_d       = err_q;
`ifdef MLP_SEQ_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl.start) begin
                    state_d     = MAC_GO;
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
                end
            end
            MAC_GO:  state_d = MAC_WAIT;
            MAC_WAIT: begin
                if (ctrl.mac_done) begin
                    state_d = relu_applies ? ACT_GO : NEXT;
                end
`ifdef MLP_SEQ_TIMEOUT_EN
                else if (expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ACT_GO:  state_d = ACT_WAIT;
            ACT_WAIT: begin
                if (ctrl.relu_done) begin
                    state_d = NEXT;
                end
`ifdef MLP_SEQ_TIMEOUT_EN
                else if (expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            NEXT: begin
                buf_sel_d = ~buf_sel_q;
                if (layer_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    layer_idx_d = layer_idx_q + LAYER_IDX_W'(1);
                    state_d     = MAC_GO;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (ctrl.start) begin
                    state_d     = MAC_GO;
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
                end
            end
`ifdef MLP_SEQ_TIMEOUT_EN
            ERR: begin
                if (ctrl.start) begin
                    state_d     = MAC_GO;
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
                    err_d       = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort wins over everything else but keeps the bank/buffer selection visible.
        if (ctrl.abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            layer_idx_d = layer_idx_q;
            buf_sel_d   = buf_sel_q;
            err_d       = 1'b0;
        end

        mac_start_d  = (state_d == MAC_GO);
        relu_start_d = (state_d == ACT_GO);
        done_d       = (state_d == DONE);
        busy_d       = (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            layer_idx_q  <= '0;
            buf_sel_q    <= 1'b0;
            err_q        <= 1'b0;
            mac_start_q  <= 1'b0;
            relu_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            layer_idx_q  <= layer_idx_d;
            buf_sel_q    <= buf_sel_d;
            err_q        <= err_d;
            mac_start_q  <= mac_start_d;
            relu_start_q <= relu_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef MLP_SEQ_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign ctrl.mac_start  = mac_start_q;
    assign ctrl.relu_start = relu_start_q;
    assign ctrl.layer_idx  = layer_idx_q;
    assign ctrl.buf_sel    = buf_sel_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;
    assign ctrl.err        = err_q;
endmodule
